pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter and return-stack block for the midrange core family, replacing the fixed 13-bit / 8-level program counter. It takes the decoder's increment, goto, call, return and interrupt requests, plus PCL/PCLATH writes from the register file, and drives the program memory address. Width, stack depth, vectors and stack-overflow behaviour are parameters. The block adds interrupt vectoring, live stack occupancy, and sticky overflow/underflow flags.

## Interface
- PC_WIDTH, 13, program counter width (11..16)
- JUMP_WIDTH, 11, width of goto/call literal (8 < JUMP_WIDTH < PC_WIDTH)
- STACK_DEPTH, 8, return stack entries (power of two, 2..32)
- RESET_VECTOR, 0, PC value after reset
- INT_VECTOR, 4, PC value loaded on interrupt
- STACK_MODE, 0, 0 = circular (classic midrange), 1 = saturating
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- pc_incr_en  in  1  PC <= PC+1
- pc_j_en  in  1  goto
- pc_j_and_push_en  in  1  call
- pc_j_by_pop_en  in  1  return
- pc_int_en  in  1  interrupt entry: push, jump to INT_VECTOR
- pc_j_addr  in  JUMP_WIDTH  goto/call literal
- pclath_wr_en  in  1  write PCLATH
- pclath_in  in  PC_WIDTH-8  PCLATH data
- pcl_wr_en  in  1  computed jump via PCL write
- pcl_in  in  8  PCL data
- pc_out  out  PC_WIDTH  current PC, registered
- pclath_out  out  8  PCLATH, zero-extended
- stack_count  out  $clog2(STACK_DEPTH+1)  valid entries
- stack_ovf  out  1  sticky push-while-full flag
- stack_unf  out  1  sticky pop-while-empty flag
- stack_err_clr  in  1  clears both sticky flags

## Operation
- One PC action per cycle, chosen by priority: int > pop > push > j > pcl write > incr. Lower-priority requests in the same cycle are dropped. With no request, PC holds.
- goto: PC <= {PCLATH[PC_WIDTH-9 : JUMP_WIDTH-8], pc_j_addr}.
- call: push PC+1, then load the same target as goto.
- int: push PC (the unexecuted instruction), then PC <= INT_VECTOR.
- return: PC <= top of stack, then pop.
- pcl write: PC <= {PCLATH, pcl_in}.
- incr: PC <= PC+1, wrapping mod 2^PC_WIDTH.
- All PC targets use the PCLATH value from before the edge. A PCLATH write in the same cycle takes effect from the next cycle.
- Stack: a pointer sp indexes the next free slot. stack_count saturates at 0 and STACK_DEPTH in both modes.
- Mode 0, push when full: sp wraps and overwrites the oldest entry. stack_ovf is set.
- Mode 0, pop when empty: sp wraps and PC loads the entry at the wrapped slot. stack_unf is set.
- Mode 1, push when full: the stack is unchanged, but PC still jumps. stack_ovf is set.
- Mode 1, pop when empty: PC <= RESET_VECTOR. stack_unf is set.
- stack_err_clr in the same cycle as a new error: the set wins.

## Timing
- All state changes on the rising clk edge. pc_out is valid one cycle after a request, with no combinational path from inputs to pc_out.
- Reset is asynchronous. The following values hold while rst is high and are released on the next edge after deassertion:
  - pc_out = RESET_VECTOR
  - PCLATH = 0
  - sp = 0, stack_count = 0
  - every stack entry = 0
  - stack_ovf = 0, stack_unf = 0
- Reset in the middle of a call/return sequence discards all in-flight stack state.
- Back-to-back call/return on consecutive cycles are supported at one per cycle.

## Structure
- Shared package core_pkg holds:
  - STACK_MODE_CIRCULAR (0) and STACK_MODE_SATURATE (1)
  - default RESET_VECTOR and INT_VECTOR
- Sub-module return_stack (PC_WIDTH, STACK_DEPTH, STACK_MODE) holds the entry array, sp, count and sticky flags. It is driven by push/pop strobes, push data and err_clr, and outputs top, count, ovf and unf.
- pc_sequencer owns the priority mux, PC and PCLATH.

## Test plan
- Reset release with defaults: pc_out = 0x0000. Three incr cycles → pc_out = 0x0003.
- PCLATH = 0x18, goto 0x123 → pc_out = 0x1923. Then call 0x010 from 0x1923 → pc_out = 0x1810, with 0x1924 pushed and stack_count = 1. Return → pc_out = 0x1924, stack_count = 0.
- Mode 0, 9 nested calls (stack_ovf = 1), then 8 returns: each return yields the most recent 8 return addresses in reverse order. A 9th return sets stack_unf.
- Mode 1, STACK_DEPTH = 2, 3 calls: the third jumps but is not pushed, and stack_ovf = 1. After 2 returns, the next return gives pc_out = RESET_VECTOR and stack_unf = 1. stack_err_clr clears both flags.
- pc_int_en and pc_incr_en together at PC = 0x0042 → pc_out = 0x0004 and 0x0042 pushed. Return → 0x0042.
- pclath_wr_en (0x01) and pcl_wr_en (0x80) in the same cycle with old PCLATH = 0 → pc_out = 0x0080. The next PCL write of 0x80 → 0x0180.
- rst asserted mid-cycle with stack_count = 3 → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the midrange core: stack-overflow modes, default
// vectors and the program-counter action encoding.
package core_pkg;

  localparam int STACK_MODE_CIRCULAR  = 0;
  localparam int STACK_MODE_SATURATE  = 1;

  localparam int DEFAULT_RESET_VECTOR = 0;
  localparam int DEFAULT_INT_VECTOR   = 4;

  // One PC action is taken per cycle, picked from the decoder requests.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INCR,
    ACT_PCL,
    ACT_JUMP,
    ACT_CALL,
    ACT_RET,
    ACT_INT
  } pc_action_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Hardware return stack: entry array, next-free pointer, saturating occupancy
// and sticky overflow/underflow flags. Push and pop are mutually exclusive.
module return_stack
  import core_pkg::*;
#(
  parameter int PC_WIDTH    = 13,
  parameter int STACK_DEPTH = 8,
  parameter int STACK_MODE  = STACK_MODE_CIRCULAR
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic [PC_WIDTH-1:0]              push_data,
  input  logic                             err_clr,
  output logic [PC_WIDTH-1:0]              top,
  output logic [$clog2(STACK_DEPTH+1)-1:0] count,
  output logic                             ovf,
  output logic                             unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(STACK_DEPTH+1);
  localparam bit CIRC  = (STACK_MODE == STACK_MODE_CIRCULAR);

  logic [PC_WIDTH-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]     sp;
  logic [SP_W-1:0]     sp_m1;
  logic                full;
  logic                empty;

  assign sp_m1 = sp - 1'b1;
  assign full  = (count == CNT_W'(STACK_DEPTH));
  assign empty = (count == '0);
  // In circular mode an empty pop reads the wrapped slot, which is also sp-1.
  assign top   = mem[sp_m1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
    end else begin
      // Clear first so a new error in the same cycle overrides it.
      if (err_clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (push) begin
        if (full) ovf <= 1'b1;
        if (!full || CIRC) begin
          mem[sp] <= push_data;
          sp      <= sp + 1'b1;
        end
        if (!full) count <= count + 1'b1;
      end else if (pop) begin
        if (empty) unf <= 1'b1;
        if (!empty || CIRC) sp <= sp_m1;
        if (!empty) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, PCLATH and request priority for the midrange core; the
// return stack lives in return_stack.
module pc_sequencer
  import core_pkg::*;
#(
  parameter int PC_WIDTH     = 13,
  parameter int JUMP_WIDTH   = 11,
  parameter int STACK_DEPTH  = 8,
  parameter int RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int INT_VECTOR   = DEFAULT_INT_VECTOR,
  parameter int STACK_MODE   = STACK_MODE_CIRCULAR
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pc_incr_en,
  input  logic                             pc_j_en,
  input  logic                             pc_j_and_push_en,
  input  logic                             pc_j_by_pop_en,
  input  logic                             pc_int_en,
  input  logic [JUMP_WIDTH-1:0]            pc_j_addr,
  input  logic                             pclath_wr_en,
  input  logic [PC_WIDTH-9:0]              pclath_in,
  input  logic                             pcl_wr_en,
  input  logic [7:0]                       pcl_in,
  output logic [PC_WIDTH-1:0]              pc_out,
  output logic [7:0]                       pclath_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             stack_ovf,
  output logic                             stack_unf,
  input  logic                             stack_err_clr
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-9:0] pclath_q;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pcl_target;
  logic [PC_WIDTH-1:0] ret_target;
  logic [PC_WIDTH-1:0] stk_top;
  logic [PC_WIDTH-1:0] push_data;
  logic                push;
  logic                pop;
  pc_action_e          action;

  always_comb begin
    action = ACT_HOLD;
    if      (pc_int_en)        action = ACT_INT;
    else if (pc_j_by_pop_en)   action = ACT_RET;
    else if (pc_j_and_push_en) action = ACT_CALL;
    else if (pc_j_en)          action = ACT_JUMP;
    else if (pcl_wr_en)        action = ACT_PCL;
    else if (pc_incr_en)       action = ACT_INCR;
  end

  assign pc_plus1    = pc_q + 1'b1;
  assign jump_target = {pclath_q[PC_WIDTH-9:JUMP_WIDTH-8], pc_j_addr};
  assign pcl_target  = {pclath_q, pcl_in};
  // A saturating stack has nothing to return to when empty, so restart.
  assign ret_target  = (STACK_MODE == STACK_MODE_SATURATE && stack_count == '0)
                       ? PC_WIDTH'(RESET_VECTOR) : stk_top;

  assign push      = (action == ACT_INT) || (action == ACT_CALL);
  assign pop       = (action == ACT_RET);
  assign push_data = (action == ACT_INT) ? pc_q : pc_plus1;

  always_comb begin
    pc_d = pc_q;
    case (action)
      ACT_INT:  pc_d = PC_WIDTH'(INT_VECTOR);
      ACT_RET:  pc_d = ret_target;
      ACT_CALL: pc_d = jump_target;
      ACT_JUMP: pc_d = jump_target;
      ACT_PCL:  pc_d = pcl_target;
      ACT_INCR: pc_d = pc_plus1;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= PC_WIDTH'(RESET_VECTOR);
      pclath_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (pclath_wr_en) pclath_q <= pclath_in;
    end
  end

  assign pc_out     = pc_q;
  assign pclath_out = 8'(pclath_q);

  return_stack #(
    .PC_WIDTH    (PC_WIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .STACK_MODE  (STACK_MODE)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .err_clr   (stack_err_clr),
    .top       (stk_top),
    .count     (stack_count),
    .ovf       (stack_ovf),
    .unf       (stack_unf)
  );

endmodule
